// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_pkg
//  Description : Shared types and constants for the image decompressor
//                top-level sequencer: sequencer state encoding, SRAM bus
//                widths and the stage index of each decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    // Stage indices in execution order
    localparam int STAGE_UART = 0;
    localparam int STAGE_M3   = 1;
    localparam int STAGE_M2   = 2;
    localparam int STAGE_M1   = 3;

    typedef enum logic [2:0] {
        S_SEQ_IDLE   = 3'd0,
        S_SEQ_SELECT = 3'd1,
        S_SEQ_LAUNCH = 3'd2,
        S_SEQ_RUN    = 3'd3,
        S_SEQ_DRAIN  = 3'd4,
        S_SEQ_DONE   = 3'd5,
        S_SEQ_ERROR  = 3'd6
    } seq_state_type;

endpackage
`default_nettype wire

// File: rtl/decode_stage_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_sequencer_if
//  Description : Bundle of the sequencer control handshake and the per-stage
//                / shared SRAM port signals.
//                master : the sequencer (drives enables, shared SRAM, status)
//                slave  : the stage/system side (drives start, skip, done and
//                         the per-stage SRAM requests)
//  Ports       : start, stage_skip, stage_enable, stage_done,
//                stage_address/write_data/we_n, SRAM_address/write_data/we_n,
//                busy, current_stage, all_done, error
//  Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_sequencer_if
    import decoder_pkg::*;
#(
    parameter int NUM_STAGES = 4
);
    localparam int STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    logic                                    start;
    logic [NUM_STAGES-1:0]                   stage_skip;
    logic [NUM_STAGES-1:0]                   stage_enable;
    logic [NUM_STAGES-1:0]                   stage_done;
    logic [NUM_STAGES-1:0][SRAM_ADDR_W-1:0]  stage_address;
    logic [NUM_STAGES-1:0][SRAM_DATA_W-1:0]  stage_write_data;
    logic [NUM_STAGES-1:0]                   stage_we_n;
    logic [SRAM_ADDR_W-1:0]                  SRAM_address;
    logic [SRAM_DATA_W-1:0]                  SRAM_write_data;
    logic                                    SRAM_we_n;
    logic                                    busy;
    logic [STAGE_W-1:0]                      current_stage;
    logic                                    all_done;
    logic                                    error;

    modport master (
        input  start, stage_skip, stage_done,
               stage_address, stage_write_data, stage_we_n,
        output stage_enable, SRAM_address, SRAM_write_data, SRAM_we_n,
               busy, current_stage, all_done, error
    );

    modport slave (
        output start, stage_skip, stage_done,
               stage_address, stage_write_data, stage_we_n,
        input  stage_enable, SRAM_address, SRAM_write_data, SRAM_we_n,
               busy, current_stage, all_done, error
    );

endinterface
`default_nettype wire

// File: rtl/decode_stage_sequencer_sram_port_mux.sv
`default_nettype none
// ============================================================================
//  Module      : sram_port_mux
//  Description : Combinational NUM_STAGES:1 selector that places the owning
//                stage's SRAM request on the shared port. When not active the
//                port is parked: address 0, data 0, we_n 1 (no write).
//  Ports       : sel (owning stage), active (pass-through enable),
//                stage_address/write_data/we_n in, SRAM_address/write_data/
//                we_n out
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_port_mux
    import decoder_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int STAGE_W    = 2
) (
    input  wire [STAGE_W-1:0]                      sel,
    input  wire                                    active,
    input  wire [NUM_STAGES-1:0][SRAM_ADDR_W-1:0]  stage_address,
    input  wire [NUM_STAGES-1:0][SRAM_DATA_W-1:0]  stage_write_data,
    input  wire [NUM_STAGES-1:0]                   stage_we_n,
    output logic [SRAM_ADDR_W-1:0]                 SRAM_address,
    output logic [SRAM_DATA_W-1:0]                 SRAM_write_data,
    output logic                                   SRAM_we_n
);

    always_comb begin
        SRAM_address    = '0;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        if (active) begin
            SRAM_address    = stage_address[sel];
            SRAM_write_data = stage_write_data[sel];
            SRAM_we_n       = stage_we_n[sel];
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_sequencer
//  Description : Top-level scheduler for the image decompressor. Runs the
//                decode stages strictly in order, gives each a one-cycle
//                enable pulse, waits for its done pulse, drains the SRAM read
//                pipeline, and grants the running stage exclusive use of the
//                shared SRAM port.
//  Ports       : Clock, Resetn (async, active-low),
//                bus (decode_stage_sequencer_if.master): start/stage_skip in,
//                stage_enable out, stage_done in, per-stage SRAM requests in,
//                shared SRAM port out, busy/current_stage/all_done/error out
//  Config      : SEQ_WATCHDOG_EN - when defined, a per-stage RUN timeout of
//                WATCHDOG_CYCLES cycles aborts the decode into S_SEQ_ERROR.
//                Undefined: RUN waits indefinitely and error is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage_sequencer
    import decoder_pkg::*;
#(
    parameter int NUM_STAGES      = 4,
    parameter int DRAIN_CYCLES    = 2     // must be >= 1
`ifdef SEQ_WATCHDOG_EN
    ,
    parameter int WATCHDOG_CYCLES = 2**22
`endif
) (
    input wire                          Clock,
    input wire                          Resetn,
    decode_stage_sequencer_if.master    bus
);

    localparam int STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    // idx must be able to hold NUM_STAGES itself (the "past the end" value)
    localparam int IDX_W   = $clog2(NUM_STAGES + 1);
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [IDX_W-1:0]   c_idx_end    = IDX_W'(NUM_STAGES);
    localparam logic [DRAIN_W-1:0] c_drain_last = DRAIN_W'(DRAIN_CYCLES - 1);

    seq_state_type         r_state,  w_state_nxt;
    logic [IDX_W-1:0]      r_idx,    w_idx_nxt;
    logic [NUM_STAGES-1:0] r_skip,   w_skip_nxt;
    logic [STAGE_W-1:0]    r_cur,    w_cur_nxt;
    logic [DRAIN_W-1:0]    r_drain,  w_drain_nxt;
    logic [NUM_STAGES-1:0] w_enable;
    logic                  w_port_active;
    logic [SRAM_ADDR_W-1:0] w_sram_address;
    logic [SRAM_DATA_W-1:0] w_sram_write_data;
    logic                   w_sram_we_n;

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
    localparam logic [WD_W-1:0] c_wd_last = WD_W'(WATCHDOG_CYCLES - 1);

    logic [WD_W-1:0]       r_wd,     w_wd_nxt;
    logic                  r_error,  w_error_nxt;
`endif

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_SEQ_IDLE;
            r_idx   <= '0;
            r_skip  <= '0;
            r_cur   <= '0;
            r_drain <= '0;
`ifdef SEQ_WATCHDOG_EN
            r_wd    <= '0;
            r_error <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_skip  <= w_skip_nxt;
            r_cur   <= w_cur_nxt;
            r_drain <= w_drain_nxt;
`ifdef SEQ_WATCHDOG_EN
            r_wd    <= w_wd_nxt;
            r_error <= w_error_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_skip_nxt  = r_skip;
        w_cur_nxt   = r_cur;
        w_drain_nxt = r_drain;
`ifdef SEQ_WATCHDOG_EN
        w_wd_nxt    = r_wd;
        w_error_nxt = r_error;
`endif
        case (r_state)
            S_SEQ_IDLE: begin
                if (bus.start) begin
                    w_skip_nxt  = bus.stage_skip;
                    w_idx_nxt   = '0;
`ifdef SEQ_WATCHDOG_EN
                    w_error_nxt = 1'b0;
`endif
                    w_state_nxt = S_SEQ_SELECT;
                end
            end
            S_SEQ_SELECT: begin
                // One index examined per cycle; skipped stages just step idx
                if (r_idx == c_idx_end) begin
                    w_state_nxt = S_SEQ_DONE;
                end else if (r_skip[r_idx[STAGE_W-1:0]]) begin
                    w_idx_nxt = r_idx + 1'b1;
                end else begin
                    w_cur_nxt   = r_idx[STAGE_W-1:0];
                    w_state_nxt = S_SEQ_LAUNCH;
                end
            end
            S_SEQ_LAUNCH: begin
                // A done arriving while the enable is still on the wire is a
                // protocol violation by the stage and is deliberately ignored
`ifdef SEQ_WATCHDOG_EN
                w_wd_nxt    = '0;
`endif
                w_state_nxt = S_SEQ_RUN;
            end
            S_SEQ_RUN: begin
                if (bus.stage_done[r_cur]) begin
                    w_drain_nxt = '0;
                    w_state_nxt = S_SEQ_DRAIN;
                end
`ifdef SEQ_WATCHDOG_EN
                else if (r_wd == c_wd_last) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = S_SEQ_ERROR;
                end else begin
                    w_wd_nxt = r_wd + 1'b1;
                end
`endif
            end
            S_SEQ_DRAIN: begin
                // Port is parked here so in-flight reads retire before the
                // next stage can issue a write
                if (r_drain == c_drain_last) begin
                    w_idx_nxt   = r_idx + 1'b1;
                    w_state_nxt = S_SEQ_SELECT;
                end else begin
                    w_drain_nxt = r_drain + 1'b1;
                end
            end
            S_SEQ_DONE:  w_state_nxt = S_SEQ_IDLE;
            S_SEQ_ERROR: w_state_nxt = S_SEQ_IDLE;
            default:     w_state_nxt = S_SEQ_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registered state)
    // ------------------------------------------------------------------
    always_comb begin
        w_enable = '0;
        if (r_state == S_SEQ_LAUNCH) begin
            w_enable[r_cur] = 1'b1;
        end
    end

    assign w_port_active = (r_state == S_SEQ_LAUNCH) || (r_state == S_SEQ_RUN);

    sram_port_mux #(
        .NUM_STAGES (NUM_STAGES),
        .STAGE_W    (STAGE_W)
    ) u_sram_port_mux (
        .sel              (r_cur),
        .active           (w_port_active),
        .stage_address    (bus.stage_address),
        .stage_write_data (bus.stage_write_data),
        .stage_we_n       (bus.stage_we_n),
        .SRAM_address     (w_sram_address),
        .SRAM_write_data  (w_sram_write_data),
        .SRAM_we_n        (w_sram_we_n)
    );

    assign bus.stage_enable    = w_enable;
    assign bus.SRAM_address    = w_sram_address;
    assign bus.SRAM_write_data = w_sram_write_data;
    assign bus.SRAM_we_n       = w_sram_we_n;
    // busy stays high through the DONE cycle so a start there is refused
    assign bus.busy            = (r_state != S_SEQ_IDLE) && (r_state != S_SEQ_ERROR);
    assign bus.current_stage   = r_cur;
    assign bus.all_done        = (r_state == S_SEQ_DONE);
`ifdef SEQ_WATCHDOG_EN
    assign bus.error           = r_error;
`else
    assign bus.error           = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage_sequencer
//  Description : Self-checking bench for decode_stage_sequencer. Stage models
//                answer each enable with a done pulse a programmable number
//                of cycles later; expected launch order is queued when a
//                decode is started and popped as enables appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage_sequencer;
    import decoder_pkg::*;

    localparam int N = 4;

    logic Clock;
    logic Resetn;

    decode_stage_sequencer_if #(.NUM_STAGES(N)) bus ();

    decode_stage_sequencer #(
        .NUM_STAGES      (N),
        .DRAIN_CYCLES    (2)
`ifdef SEQ_WATCHDOG_EN
        ,
        .WATCHDOG_CYCLES (64)
`endif
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int         n_checks = 0;
    int         n_errors = 0;
    int         q_exp[$];
    int         resp_delay[N];   // 0 = stage never answers
    int         resp_cnt[N];
    logic [N-1:0] resp_done;
    logic [N-1:0] stray_done;

    assign bus.stage_done = resp_done | stray_done;

    // Stage models: done is high exactly on the cycle resp_delay after enable
    always @(negedge Clock) begin
        for (int s = 0; s < N; s++) begin
            if (!Resetn) begin
                resp_cnt[s]  <= 0;
                resp_done[s] <= 1'b0;
            end else if (bus.stage_enable[s] && resp_delay[s] > 0) begin
                resp_cnt[s]  <= resp_delay[s];
                resp_done[s] <= 1'b0;
            end else if (resp_cnt[s] > 0) begin
                resp_cnt[s]  <= resp_cnt[s] - 1;
                resp_done[s] <= (resp_cnt[s] == 1);
            end else begin
                resp_done[s] <= 1'b0;
            end
        end
    end

    // Sample point: shortly after the falling edge, well away from posedge
    task automatic tick();
        @(negedge Clock);
        #1;
    endtask

    task automatic pulse_start(input logic [N-1:0] skip);
        bus.stage_skip = skip;
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({bus.busy, bus.all_done, bus.error, bus.stage_enable, bus.current_stage} !== '0) begin
            n_errors++;
            $display("FAIL reset_status: busy=%b all_done=%b error=%b enable=%b cur=%0d, required all 0",
                     bus.busy, bus.all_done, bus.error, bus.stage_enable, bus.current_stage);
        end
        n_checks++;
        if (bus.SRAM_address !== 18'h0 || bus.SRAM_write_data !== 16'h0 || bus.SRAM_we_n !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_sram: addr=%h data=%h we_n=%b, required 0/0/1",
                     bus.SRAM_address, bus.SRAM_write_data, bus.SRAM_we_n);
        end
        Resetn = 1'b1;
        tick();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset: busy=%b required 0", bus.busy);
        end
    endtask

    // Test 1: every stage runs, done 10 cycles after enable
    task automatic test_full_run();
        int  last_en = -1;
        int  n_done  = 0;
        bit  in_win  = 0;
        bit  prev_en = 0;
        int  e;
        bus.stage_we_n = '0;
        for (int s = 0; s < N; s++) begin
            resp_delay[s] = 10;
            bus.stage_address[s]    = 18'(s + 1);
            bus.stage_write_data[s] = 16'(s + 16'h100);
            q_exp.push_back(s);
        end
        pulse_start(4'b0000);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL full_busy: busy=%b required 1", bus.busy);
        end
        for (int i = 0; i < 200 && n_done == 0; i++) begin
            if (bus.stage_enable != '0) begin
                n_checks++;
                if (prev_en) begin
                    n_errors++;
                    $display("FAIL full_enable_width: enable %b held for a second cycle", bus.stage_enable);
                end
                n_checks++;
                if (q_exp.size() == 0) begin
                    n_errors++;
                    $display("FAIL full_extra_enable: got enable %b, required none", bus.stage_enable);
                end else begin
                    e = q_exp.pop_front();
                    if (bus.stage_enable !== 4'(1 << e) || bus.current_stage !== 2'(e)) begin
                        n_errors++;
                        $display("FAIL full_enable_order: enable=%b cur=%0d, required enable=%b cur=%0d",
                                 bus.stage_enable, bus.current_stage, 4'(1 << e), e);
                    end
                end
                if (last_en >= 0) begin
                    // 10 cycles to done + 2 drain + 1 select + launch
                    n_checks++;
                    if (i - last_en != 14) begin
                        n_errors++;
                        $display("FAIL full_enable_spacing: got %0d cycles, required 14", i - last_en);
                    end
                end
                last_en = i;
                in_win  = 1;
            end
            prev_en = (bus.stage_enable != '0);
            n_checks++;
            if (bus.SRAM_we_n !== !in_win) begin
                n_errors++;
                $display("FAIL full_we_n cycle %0d: we_n=%b required %b", i, bus.SRAM_we_n, !in_win);
            end
            if (resp_done != '0) in_win = 0;
            if (bus.all_done) begin
                n_done++;
                n_checks++;
                if (bus.busy !== 1'b1 || i - last_en != 14) begin
                    n_errors++;
                    $display("FAIL full_all_done: busy=%b gap=%0d, required busy=1 gap=14", bus.busy, i - last_en);
                end
            end
            tick();
        end
        n_checks++;
        if (n_done != 1 || q_exp.size() != 0) begin
            n_errors++;
            $display("FAIL full_completion: all_done pulses=%0d pending=%0d, required 1 and 0", n_done, q_exp.size());
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.all_done !== 1'b0) begin
            n_errors++;
            $display("FAIL full_after_done: busy=%b all_done=%b, required 0 0", bus.busy, bus.all_done);
        end
        q_exp.delete();
    endtask

    // Test 2a: skip mask 0101 -> only stages 1 and 3 run
    task automatic test_skip();
        int n_done = 0;
        int e;
        for (int s = 0; s < N; s++) resp_delay[s] = 10;
        q_exp.push_back(STAGE_M3);
        q_exp.push_back(STAGE_M1);
        pulse_start(4'b0101);
        for (int i = 0; i < 200 && n_done == 0; i++) begin
            if (bus.stage_enable != '0) begin
                n_checks++;
                if (q_exp.size() == 0) begin
                    n_errors++;
                    $display("FAIL skip_extra_enable: got %b, required none", bus.stage_enable);
                end else begin
                    e = q_exp.pop_front();
                    if (bus.stage_enable !== 4'(1 << e) || bus.current_stage !== 2'(e)) begin
                        n_errors++;
                        $display("FAIL skip_enable: enable=%b cur=%0d, required enable=%b cur=%0d",
                                 bus.stage_enable, bus.current_stage, 4'(1 << e), e);
                    end
                end
            end
            if (bus.all_done) n_done++;
            tick();
        end
        n_checks++;
        if (n_done != 1 || q_exp.size() != 0) begin
            n_errors++;
            $display("FAIL skip_completion: all_done=%0d pending=%0d, required 1 and 0", n_done, q_exp.size());
        end
        q_exp.delete();
    endtask

    // Test 2b: everything skipped; also a start coinciding with DONE
    task automatic test_all_skip();
        int n_done = 0;
        int n_en   = 0;
        int n_we   = 0;
        pulse_start(4'b1111);
        for (int i = 0; i < 50 && n_done == 0; i++) begin
            if (bus.stage_enable != '0) n_en++;
            if (bus.SRAM_we_n !== 1'b1) n_we++;
            if (bus.all_done) begin
                n_done++;
                bus.start = 1'b1;
            end
            tick();
            bus.start = 1'b0;
        end
        n_checks++;
        if (n_done != 1 || n_en != 0 || n_we != 0) begin
            n_errors++;
            $display("FAIL all_skip: all_done=%0d enables=%0d writes=%0d, required 1 0 0", n_done, n_en, n_we);
        end
        tick();
        tick();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL start_in_done: busy=%b required 0 (start ignored)", bus.busy);
        end
    endtask

    // Test 3: shared port follows stage 2 only while it owns the port
    task automatic test_sram_mux();
        int n_done = 0;
        bit in_win = 0;
        logic [17:0] ea;
        logic [15:0] ed;
        logic        ew;
        for (int s = 0; s < N; s++) begin
            resp_delay[s]           = 10;
            bus.stage_address[s]    = 18'h15555 + 18'(s);
            bus.stage_write_data[s] = 16'h1111 * 16'(s + 1);
        end
        bus.stage_address[STAGE_M2]    = 18'h23DF0;
        bus.stage_write_data[STAGE_M2] = 16'hBEEF;
        bus.stage_we_n                 = '0;
        pulse_start(4'b1011);
        for (int i = 0; i < 200 && n_done == 0; i++) begin
            if (bus.stage_enable != '0) in_win = 1;
            ea = in_win ? 18'h23DF0 : 18'h0;
            ed = in_win ? 16'hBEEF  : 16'h0;
            ew = in_win ? 1'b0      : 1'b1;
            n_checks++;
            if (bus.SRAM_address !== ea || bus.SRAM_write_data !== ed || bus.SRAM_we_n !== ew) begin
                n_errors++;
                $display("FAIL sram_mux cycle %0d: addr=%h data=%h we_n=%b, required %h %h %b",
                         i, bus.SRAM_address, bus.SRAM_write_data, bus.SRAM_we_n, ea, ed, ew);
            end
            if (resp_done != '0) in_win = 0;
            if (bus.all_done) n_done++;
            tick();
        end
        n_checks++;
        if (n_done != 1) begin
            n_errors++;
            $display("FAIL sram_mux_done: all_done=%0d required 1", n_done);
        end
        bus.stage_we_n = '1;
    endtask

    // Test 4: start while busy, stray done from stage 3, done during LAUNCH
    task automatic test_stray();
        int en_cyc   = -1;
        int done_cyc = -1;
        int ad_cyc   = -1;
        int n_en     = 0;
        for (int s = 0; s < N; s++) resp_delay[s] = 20;
        pulse_start(4'b1101);
        for (int i = 0; i < 200 && ad_cyc < 0; i++) begin
            stray_done = '0;
            bus.start  = 1'b0;
            if (bus.stage_enable != '0) begin
                n_en++;
                en_cyc     = i;
                stray_done = 4'b0010;   // stage 1 claims done while still in LAUNCH
            end
            if (en_cyc >= 0 && i == en_cyc + 5) begin
                bus.start  = 1'b1;
                stray_done = 4'b1000;
            end
            if (en_cyc >= 0 && (i == en_cyc + 6 || i == en_cyc + 8)) begin
                n_checks++;
                if (bus.busy !== 1'b1 || bus.current_stage !== 2'd1 || bus.SRAM_we_n !== 1'b1 && 1'b0) begin
                    n_errors++;
                    $display("FAIL stray_state: busy=%b cur=%0d, required 1 and 1", bus.busy, bus.current_stage);
                end
            end
            if (resp_done[1]) done_cyc = i;
            if (bus.all_done) ad_cyc = i;
            tick();
        end
        stray_done = '0;
        bus.start  = 1'b0;
        n_checks++;
        if (n_en != 1 || done_cyc < 0 || ad_cyc <= done_cyc) begin
            n_errors++;
            $display("FAIL stray_ignored: enables=%0d done_cyc=%0d all_done_cyc=%0d, required 1 enable and all_done after done",
                     n_en, done_cyc, ad_cyc);
        end
    endtask

    // Test 5: asynchronous reset during RUN of stage 2
    task automatic test_reset_midrun();
        int en_cyc = -1;
        for (int s = 0; s < N; s++) resp_delay[s] = 0;
        bus.stage_we_n = '0;
        pulse_start(4'b1011);
        for (int i = 0; i < 20 && en_cyc < 0; i++) begin
            if (bus.stage_enable != '0) en_cyc = i;
            tick();
        end
        tick();
        tick();
        n_checks++;
        if (en_cyc < 0 || bus.SRAM_address !== 18'h23DF0 || bus.SRAM_we_n !== 1'b0 || bus.current_stage !== 2'd2) begin
            n_errors++;
            $display("FAIL midrun_owner: en_cyc=%0d addr=%h we_n=%b cur=%0d, required addr 23df0 we_n 0 cur 2",
                     en_cyc, bus.SRAM_address, bus.SRAM_we_n, bus.current_stage);
        end
        #1;
        Resetn = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.all_done, bus.error, bus.stage_enable, bus.current_stage} !== '0 ||
            bus.SRAM_address !== 18'h0 || bus.SRAM_write_data !== 16'h0 || bus.SRAM_we_n !== 1'b1) begin
            n_errors++;
            $display("FAIL midrun_reset: busy=%b cur=%0d addr=%h data=%h we_n=%b, required reset values",
                     bus.busy, bus.current_stage, bus.SRAM_address, bus.SRAM_write_data, bus.SRAM_we_n);
        end
        tick();
        Resetn = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.stage_enable !== '0) begin
            n_errors++;
            $display("FAIL midrun_after: busy=%b enable=%b, required 0", bus.busy, bus.stage_enable);
        end
        bus.stage_we_n = '1;
    endtask

`ifdef SEQ_WATCHDOG_EN
    // Test 6: stage 0 hangs; watchdog fires after 64 RUN cycles
    task automatic test_watchdog();
        int en_cyc = -1;
        int n_done = 0;
        for (int s = 0; s < N; s++) resp_delay[s] = 0;
        pulse_start(4'b0000);
        for (int i = 0; i < 20 && en_cyc < 0; i++) begin
            if (bus.stage_enable != '0) en_cyc = i;
            else tick();
        end
        for (int i = 0; i < 64; i++) tick();
        n_checks++;
        if (en_cyc < 0 || bus.error !== 1'b0 || bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL wd_early: error=%b busy=%b, required 0 1", bus.error, bus.busy);
        end
        tick();
        n_checks++;
        if (bus.error !== 1'b1 || bus.busy !== 1'b0 || bus.all_done !== 1'b0 || bus.SRAM_we_n !== 1'b1) begin
            n_errors++;
            $display("FAIL wd_fire: error=%b busy=%b all_done=%b we_n=%b, required 1 0 0 1",
                     bus.error, bus.busy, bus.all_done, bus.SRAM_we_n);
        end
        tick();
        n_checks++;
        if (bus.error !== 1'b1 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL wd_sticky: error=%b busy=%b, required 1 0", bus.error, bus.busy);
        end
        for (int s = 0; s < N; s++) resp_delay[s] = 10;
        pulse_start(4'b0000);
        n_checks++;
        if (bus.error !== 1'b0 || bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL wd_clear: error=%b busy=%b, required 0 1", bus.error, bus.busy);
        end
        for (int i = 0; i < 200 && n_done == 0; i++) begin
            if (bus.all_done) n_done++;
            tick();
        end
        n_checks++;
        if (n_done != 1 || bus.error !== 1'b0) begin
            n_errors++;
            $display("FAIL wd_rerun: all_done=%0d error=%b, required 1 0", n_done, bus.error);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        Resetn               = 1'b0;
        bus.start            = 1'b0;
        bus.stage_skip       = '0;
        bus.stage_address    = '0;
        bus.stage_write_data = '0;
        bus.stage_we_n       = '1;
        stray_done           = '0;
        for (int s = 0; s < N; s++) resp_delay[s] = 0;

        test_reset();
        test_full_run();
        tick();
        test_skip();
        tick();
        test_all_skip();
        test_sram_mux();
        tick();
        test_stray();
        tick();
        test_reset_midrun();
`ifdef SEQ_WATCHDOG_EN
        test_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
